uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Parametrised successor to the existing single-byte uart peripheral on the m68k system bus: same 16-bit uds/lds/rw slave interface, 8N1 serial line.
- Adds TX and RX FIFOs of configurable depth, a status/control register, sticky error flags and an interrupt output.
- Sits beside the existing uart in the computer I/O space.
- Its strobes and signals are drop-in for the testbench uart task: byte in [15:8] via uds; rx_avail and tx_active are retained.

Parameters:
- CLK_HZ, 25000000, clk frequency in Hz.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer, must be >= 4).
- TX_DEPTH, 16, TX FIFO entries, power of 2, 2..256.
- RX_DEPTH, 16, RX FIFO entries, power of 2, 2..256.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input (asynchronous, idle high).
- tx  out  1  serial output (idle high).
- addr  in  1  0 = data register, 1 = status/control register.
- rw  in  1  1 = read, 0 = write.
- uds  in  1  upper byte strobe, selects [15:8].
- lds  in  1  lower byte strobe, selects [7:0].
- data_write  in  16  write data.
- data_read  out  16  registered read data.
- rx_avail  out  1  RX FIFO non-empty.
- tx_active  out  1  transmitter busy or TX FIFO non-empty.
- irq  out  1  level interrupt request.

Behaviour:
- Single clock domain. reset_n asserted asynchronously clears all state.
  - Reset values: tx=1, data_read=0, rx_avail=0, tx_active=0, irq=0. FIFOs empty, flags and enables cleared.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Bus access: an action fires once, on the first clk where (uds|lds) rises from 0 to 1 (edge-detected). Strobes held for many cycles do not repeat the action.
- Write addr 0 with uds: push data_write[15:8] to TX FIFO. If TX is full, the write is ignored.
- Read addr 0 with uds: data_read[15:8] <= RX head, then pop; data_read[7:0] <= 0.
  - RX empty: data_read returns 0x0000 and no pop occurs.
  - data_read is valid 1 clk after the strobe edge and held until the next read capture.
- Read addr 1: data_read[15:8] = {irq_en_rx, irq_en_tx, ferr, ovr, tx_full, tx_empty, rx_full, rx_avail}; data_read[7:0] = RX count (9-bit count saturated to 255).
- Write addr 1 with uds:
  - bits 15:14 load irq_en_rx and irq_en_tx.
  - bit 13 = 1 clears ferr; bit 12 = 1 clears ovr.
- lds-only accesses: reads return [7:0] per the map above; writes are ignored.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE. Each state/bit lasts DIV clks.
  - Leaves IDLE in the clk after the FIFO becomes non-empty and pops the byte on leaving.
  - Back-to-back frames have no idle gap.
- tx_active = (FSM != IDLE) | TX non-empty.
- RX path: 2-flop synchroniser feeding FSM IDLE -> START -> DATA -> STOP.
  - Falling edge in IDLE starts a counter; at DIV/2 the line is re-checked. High means a glitch: return to IDLE.
  - Data bits are then sampled every DIV clks (bit centres); the stop bit is sampled likewise.
  - Stop = 1: byte pushed to RX.
  - Stop = 0: byte discarded, ferr set, wait for line high before re-arming.
- RX push while RX full: byte dropped, ovr set (sticky). If a bus pop occurs in the same clk, the pop happens first, the push is accepted, and ovr is not set.
- Push and pop on the same FIFO in the same clk: both occur, count unchanged.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full = MSBs differ and the rest are equal.
- irq = (irq_en_rx & rx_avail) | (irq_en_tx & ~tx_active), registered (1 clk latency).

Optional Feature:
- UART_PARITY_EN defined: even parity bit inserted after DATA on both TX and RX (frame of 11 bits).
  - RX parity mismatch: byte is discarded and status bit pe (data_read[7] of addr 1) is set. The RX count then occupies [6:0], saturated to 127.
  - Writing addr 1 with lds and bit 7 = 1 clears pe.
- Undefined: 8N1 only; no parity logic, and the RX count uses all of [7:0].

Test Plan:
- Setup for all scenarios: CLK_HZ=1000000, BAUD=100000 (DIV=10).
- Reset then write 0x55 to addr 0 -> tx low 1 clk later for 10 clks; bits 1,0,1,0,1,0,1,0 at 10-clk spacing; stop high; tx_active falls 100 clks after start.
- Push 17 bytes 0x00..0x10 with TX_DEPTH=16 while idle -> first byte pops at once, the next 16 are queued; all 17 are transmitted in order with no gaps.
- Loop tx to rx, send 0xA3 -> rx_avail=1 after the stop sample; status count=1; read addr 0 gives 0xA300 and rx_avail drops.
- Drive 17 frames into rx with no reads, RX_DEPTH=16 -> count=16 and ovr=1; write addr 1 with bit 12 -> ovr=0.
- Drive a frame with stop=0 -> no push and ferr=1. Drive a 3-clk low glitch -> no frame started.
- Set irq_en_rx, receive one byte -> irq=1 the clk after rx_avail. Assert reset_n low mid-TX frame -> tx=1 and irq=0 immediately.

Source files
------------

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - m68k-bus UART with TX/RX FIFOs, status/control register and irq; optional even parity via UART_PARITY_EN
`timescale 1ns/1ps

module uart_fifo #(
    parameter int CLK_HZ   = 25000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic        tx,
    input  logic        addr,
    input  logic        rw,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        rx_avail,
    output logic        tx_active,
    output logic        irq
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

    // bus strobe edge detection and decoded actions
    logic r_strb_d;
    logic w_fire, w_wr_data, w_rd_data, w_wr_ctrl;
    assign w_fire    = (uds | lds) & ~r_strb_d;
    assign w_wr_data = w_fire & ~rw & ~addr & uds;
    assign w_rd_data = w_fire & rw & ~addr & uds;
    assign w_wr_ctrl = w_fire & ~rw & addr & uds;

    // previous strobe level so a held strobe acts only once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_strb_d <= 1'b0;
        else          r_strb_d <= uds | lds;
    end

    // TX FIFO
    logic [7:0] r_tx_mem [TX_DEPTH];
    logic [TAW:0] r_tx_wr, r_tx_rd;
    logic w_tx_empty, w_tx_full, w_tx_push, w_tx_load;
    logic [7:0] w_tx_head;
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[TAW] != r_tx_rd[TAW]) && (r_tx_wr[TAW-1:0] == r_tx_rd[TAW-1:0]);
    assign w_tx_push  = w_wr_data & ~w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rd[TAW-1:0]];

    // TX storage write
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[TAW-1:0]] <= data_write[15:8];
    end

    // TX pointers: push from the bus, pop when the transmitter loads a byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_load) r_tx_rd <= r_tx_rd + 1'b1;
        end
    end

    // TX serialiser
    tx_state_t  r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0] r_tx_shift;
    logic [2:0] r_tx_bit;
    logic       r_tx;
`ifdef UART_PARITY_EN
    logic       r_tx_par;
`endif
    assign w_tx_load = ~w_tx_empty &
                       ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && (r_tx_cnt == DIV_M1)));

    // TX frame FSM; stop-to-start chaining keeps back-to-back frames gapless
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= w_tx_head;
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b0;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^w_tx_head;
`endif
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx_state <= TX_PAR;
                            r_tx       <= r_tx_par;
`else
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_PAR: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (w_tx_load) begin
                            r_tx_state <= TX_START;
                            r_tx_shift <= w_tx_head;
                            r_tx       <= 1'b0;
`ifdef UART_PARITY_EN
                            r_tx_par   <= ^w_tx_head;
`endif
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX line synchroniser, idle high
    logic r_rx_s1, r_rx_s2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // RX deserialiser
    rx_state_t  r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_bit;
    logic       w_rx_end, w_stop_smp, w_rx_push, w_ferr_set;
`ifdef UART_PARITY_EN
    logic       r_rx_perr;
    logic       w_pe_set;
`endif
    assign w_rx_end   = (r_rx_cnt == DIV_M1);
    assign w_stop_smp = (r_rx_state == RX_STOP) & w_rx_end;
    assign w_ferr_set = w_stop_smp & ~r_rx_s2;
`ifdef UART_PARITY_EN
    assign w_rx_push  = w_stop_smp & r_rx_s2 & ~r_rx_perr;
    assign w_pe_set   = w_stop_smp & r_rx_s2 & r_rx_perr;
`else
    assign w_rx_push  = w_stop_smp & r_rx_s2;
`endif

    // RX frame FSM: half-bit start re-check, then centre sampling every DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PAR;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_STOP;
`ifdef UART_PARITY_EN
                        r_rx_perr  <= r_rx_s2 ^ (^r_rx_shift);
`endif
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (r_rx_s2) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // RX FIFO; a same-clock bus pop frees the slot for a push into a full FIFO
    logic [7:0] r_rx_mem [RX_DEPTH];
    logic [RAW:0] r_rx_wr, r_rx_rd;
    logic [RAW:0] w_rx_diff;
    logic [8:0] w_rx_count;
    logic w_rx_empty, w_rx_full, w_rx_pop, w_rx_accept, w_ovr_set;
    logic [7:0] w_rx_head;
    assign w_rx_empty  = (r_rx_wr == r_rx_rd);
    assign w_rx_full   = (r_rx_wr[RAW] != r_rx_rd[RAW]) && (r_rx_wr[RAW-1:0] == r_rx_rd[RAW-1:0]);
    assign w_rx_pop    = w_rd_data & ~w_rx_empty;
    assign w_rx_accept = w_rx_push & (~w_rx_full | w_rx_pop);
    assign w_ovr_set   = w_rx_push & w_rx_full & ~w_rx_pop;
    assign w_rx_head   = r_rx_mem[r_rx_rd[RAW-1:0]];
    assign w_rx_diff   = r_rx_wr - r_rx_rd;
    assign w_rx_count  = 9'(w_rx_diff);

    // RX storage write
    always_ff @(posedge clk) begin
        if (w_rx_accept) r_rx_mem[r_rx_wr[RAW-1:0]] <= r_rx_shift;
    end

    // RX pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else begin
            if (w_rx_accept) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)    r_rx_rd <= r_rx_rd + 1'b1;
        end
    end

    // control enables and sticky error flags; a new error wins over a clear
    logic r_en_rx, r_en_tx, r_ferr, r_ovr;
`ifdef UART_PARITY_EN
    logic r_pe;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_rx <= 1'b0;
            r_en_tx <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_PARITY_EN
            r_pe    <= 1'b0;
`endif
        end else begin
            if (w_wr_ctrl) begin
                r_en_rx <= data_write[15];
                r_en_tx <= data_write[14];
            end
            if (w_ferr_set)                        r_ferr <= 1'b1;
            else if (w_wr_ctrl && data_write[13])  r_ferr <= 1'b0;
            if (w_ovr_set)                         r_ovr  <= 1'b1;
            else if (w_wr_ctrl && data_write[12])  r_ovr  <= 1'b0;
`ifdef UART_PARITY_EN
            if (w_pe_set)                                          r_pe <= 1'b1;
            else if (w_fire && !rw && addr && lds && data_write[7]) r_pe <= 1'b0;
`endif
        end
    end

    // read mux: upper byte only on uds, lower byte carries the RX count
    logic [7:0] w_status, w_cnt_field, w_rd_hi, w_rd_lo;
    logic       w_tx_active;
    assign w_tx_active = (r_tx_state != TX_IDLE) | ~w_tx_empty;
    assign w_status = {r_en_rx, r_en_tx, r_ferr, r_ovr, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};
`ifdef UART_PARITY_EN
    assign w_cnt_field = {r_pe, (w_rx_count > 9'd127) ? 7'h7F : w_rx_count[6:0]};
`else
    assign w_cnt_field = (w_rx_count > 9'd255) ? 8'hFF : w_rx_count[7:0];
`endif

    // read data selection
    always_comb begin
        w_rd_hi = 8'h00;
        w_rd_lo = 8'h00;
        if (addr) begin
            w_rd_hi = w_status;
            w_rd_lo = w_cnt_field;
        end else if (!w_rx_empty) begin
            w_rd_hi = w_rx_head;
        end
    end

    // read capture and registered interrupt
    logic [15:0] r_data_read;
    logic        r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_read <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_fire && rw) r_data_read <= {uds ? w_rd_hi : 8'h00, w_rd_lo};
            r_irq <= (r_en_rx & ~w_rx_empty) | (r_en_tx & ~w_tx_active);
        end
    end

`ifdef UART_PARITY_EN
    logic w_unused;
    assign w_unused = &{1'b0, data_write[11:8], data_write[6:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, data_write[11:0]};
`endif

    assign tx        = r_tx;
    assign data_read = r_data_read;
    assign rx_avail  = ~w_rx_empty;
    assign tx_active = w_tx_active;
    assign irq       = r_irq;

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized self-checking bench for uart_fifo against a queue-based model
`timescale 1ns/1ps

module tb_uart_fifo;

    localparam int DIV   = 10;
    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rx;
    logic        tx;
    logic        addr = 1'b0;
    logic        rw = 1'b1;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic [15:0] data_write = 16'h0000;
    logic [15:0] data_read;
    logic        rx_avail;
    logic        tx_active;
    logic        irq;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo #(.CLK_HZ(1000000), .BAUD(100000), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .tx(tx), .addr(addr), .rw(rw),
        .uds(uds), .lds(lds), .data_write(data_write), .data_read(data_read),
        .rx_avail(rx_avail), .tx_active(tx_active), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0]  tq[$];
    logic [7:0]  rq[$];
    int          m_t = -1;
    logic [7:0]  m_cur = 8'h00;
    logic        m_en_rx = 0, m_en_tx = 0, m_ferr = 0, m_ovr = 0, m_irq = 0, m_prev = 0;
    logic [15:0] m_dr = 16'h0000;
    logic        m_rx_busy = 0;
    logic        cmp_en = 0;

    function automatic logic m_tx_bit();
        int slot;
        if (m_t < 0) return 1'b1;
        slot = m_t / DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    function automatic logic m_active();
        return (m_t >= 0) || (tq.size() != 0);
    endfunction

    function automatic logic [15:0] m_status();
        return {m_en_rx, m_en_tx, m_ferr, m_ovr, tq.size() == 16, tq.size() == 0,
                rq.size() == 16, rq.size() != 0, 8'(rq.size())};
    endfunction

    task automatic model_reset();
        tq.delete();
        rq.delete();
        m_t = -1; m_cur = 8'h00;
        m_en_rx = 0; m_en_tx = 0; m_ferr = 0; m_ovr = 0; m_irq = 0; m_prev = 0;
        m_dr = 16'h0000;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // model advances one clock using pre-edge state
    always @(posedge clk) begin : model
        logic strb, fire, irq_next;
        int pre_tq;
        if (reset_n) begin
            strb = uds | lds;
            fire = strb && !m_prev;
            m_prev = strb;
            irq_next = (m_en_rx && rq.size() != 0) || (m_en_tx && !m_active());
            pre_tq = tq.size();
            if (fire && rw) begin
                if (addr) m_dr = m_status();
                else if (rq.size() != 0) m_dr = {rq.pop_front(), 8'h00};
                else m_dr = 16'h0000;
            end
            if (m_t >= 0) begin
                m_t++;
                if (m_t == FRAME * DIV) m_t = -1;
            end
            if (m_t < 0 && pre_tq > 0) begin
                m_cur = tq.pop_front();
                m_t = 0;
            end
            if (fire && !rw && uds) begin
                if (!addr) begin
                    if (pre_tq < 16) tq.push_back(data_write[15:8]);
                end else begin
                    m_en_rx = data_write[15];
                    m_en_tx = data_write[14];
                    if (data_write[13]) m_ferr = 0;
                    if (data_write[12]) m_ovr = 0;
                end
            end
            m_irq = irq_next;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx", 16'(tx), 16'(m_tx_bit()));
            chk("tx_active", 16'(tx_active), 16'(m_active()));
            chk("data_read", data_read, m_dr);
            if (!m_rx_busy) begin
                chk("rx_avail", 16'(rx_avail), 16'(rq.size() != 0));
                chk("irq", 16'(irq), 16'(m_irq));
            end
        end
    end

    task automatic bus(input logic a, input logic r, input logic [15:0] d, input int hold);
        @(negedge clk);
        addr = a; rw = r; data_write = d; uds = 1'b1;
        repeat (hold) @(negedge clk);
        uds = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic a, output logic [15:0] v);
        bus(a, 1'b1, 16'h0000, 1);
        #1 v = data_read;
    endtask

    task automatic wait_tx_idle(input int budget);
        int n;
        n = 0;
        while (m_active() && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL tx_idle_timeout actual=%0d expected<%0d", n, budget);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        m_rx_busy = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = fr[i];
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (15) @(negedge clk);
        if (stop_bit) begin
            if (rq.size() < 16) rq.push_back(b);
            else m_ovr = 1;
        end else begin
            m_ferr = 1;
        end
        repeat (2) @(negedge clk);
        m_rx_busy = 0;
    endtask

    task automatic glitch();
        m_rx_busy = 1;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        m_rx_busy = 0;
    endtask

    task automatic poll_irq();
        logic found;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            #1;
            if (rx_avail) begin
                found = 1;
                chk("irq_before_latency", 16'(irq), 16'h0000);
                @(negedge clk);
                #1;
                chk("irq_after_rx_avail", 16'(irq), 16'h0001);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rx_avail_timeout actual=0 expected=1");
        end
    endtask

    initial begin
        logic [15:0] v;
        int nb;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", 16'(tx), 16'h0001);
        chk("reset_data_read", data_read, 16'h0000);
        chk("reset_rx_avail", 16'(rx_avail), 16'h0000);
        chk("reset_tx_active", 16'(tx_active), 16'h0000);
        chk("reset_irq", 16'(irq), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en = 1;

        // single byte 0x55: literal bit timing
        bus(1'b0, 1'b0, 16'h5500, 1);
        for (int n = 1; n <= 101; n++) begin
            @(negedge clk);
            #1;
            if (n == 1)   chk("t55_start", 16'(tx), 16'h0000);
            if (n == 11)  chk("t55_bit0", 16'(tx), 16'h0001);
            if (n == 21)  chk("t55_bit1", 16'(tx), 16'h0000);
            if (n == 91)  chk("t55_stop", 16'(tx), 16'h0001);
            if (n == 100) chk("t55_active_end", 16'(tx_active), 16'h0001);
            if (n == 101) chk("t55_active_fall", 16'(tx_active), 16'h0000);
        end

        // 17 bytes into a 16-deep TX FIFO
        for (int i = 0; i <= 16; i++) bus(1'b0, 1'b0, {8'(i), 8'h00}, 1);
        rd(1'b1, v);
        chk("tx_full_status", v, 16'h0800);
        wait_tx_idle(3000);

        // random bytes with long-held strobes
        nb = $urandom_range(3, 6);
        for (int i = 0; i < nb; i++) bus(1'b0, 1'b0, {8'($urandom), 8'h00}, $urandom_range(1, 4));
        wait_tx_idle(2000);

        // loopback 0xA3
        loop_en = 1'b1;
        m_rx_busy = 1;
        bus(1'b0, 1'b0, 16'hA300, 1);
        wait_tx_idle(500);
        repeat (20) @(negedge clk);
        rq.push_back(8'hA3);
        repeat (2) @(negedge clk);
        m_rx_busy = 0;
        loop_en = 1'b0;
        rd(1'b1, v);
        chk("loop_status", v, 16'h0501);
        rd(1'b0, v);
        chk("loop_data", v, 16'hA300);
        chk("loop_rx_avail_drop", 16'(rx_avail), 16'h0000);

        // overrun with 17 random frames
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        rd(1'b1, v);
        chk("ovr_status", v, 16'h1710);
        bus(1'b1, 1'b0, 16'h1000, 1);
        rd(1'b1, v);
        chk("ovr_cleared", v, 16'h0710);
        for (int i = 0; i < 16; i++) rd(1'b0, v);
        rd(1'b0, v);
        chk("rx_empty_read", v, 16'h0000);

        // framing error and glitch rejection
        send_frame(8'h5A, 1'b0);
        rd(1'b1, v);
        chk("ferr_status", v, 16'h2400);
        glitch();
        rd(1'b1, v);
        chk("glitch_status", v, 16'h2400);
        bus(1'b1, 1'b0, 16'h2000, 1);

        // receive interrupt latency
        bus(1'b1, 1'b0, 16'h8000, 1);
        fork
            send_frame(8'($urandom), 1'b1);
            poll_irq();
        join
        bus(1'b1, 1'b0, 16'hC000, 1);
        repeat (5) @(negedge clk);

        // reset in the middle of a TX frame
        bus(1'b0, 1'b0, 16'h3C00, 1);
        repeat (30) @(negedge clk);
        #1 chk("irq_pre_reset", 16'(irq), 16'h0001);
        @(posedge clk);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_tx", 16'(tx), 16'h0001);
        chk("midreset_irq", 16'(irq), 16'h0000);
        chk("midreset_tx_active", 16'(tx_active), 16'h0000);
        chk("midreset_rx_avail", 16'(rx_avail), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        bus(1'b0, 1'b0, {8'($urandom), 8'h00}, 1);
        wait_tx_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
